// File: rtl/fb_rect_fill.sv
// Avalon-MM write master that fills a framebuffer rectangle with a constant colour.
// Optional completion interrupt: define RECT_FILL_IRQ_EN to add the irq port.
module fb_rect_fill #(
    parameter int MAX_DIM = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  slave_address,
    input  logic        slave_read_en,
    input  logic        slave_write_en,
    output logic [31:0] slave_read_data,
    input  logic [31:0] slave_write_data,
    output logic [31:0] master_address,
    output logic        master_write,
    output logic [31:0] master_write_data,
    input  logic        master_wait_request
`ifdef RECT_FILL_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [2:0] A_BASE   = 3'd0;
    localparam logic [2:0] A_STRIDE = 3'd1;
    localparam logic [2:0] A_DIMS   = 3'd2;
    localparam logic [2:0] A_COLOUR = 3'd3;
    localparam logic [2:0] A_CTRL   = 3'd4;
    localparam logic [2:0] A_FILLS  = 3'd5;

    state_t             state_q, state_d;
    logic [31:0]        base_q, base_d;
    logic [31:0]        stride_q, stride_d;
    logic [31:0]        colour_q, colour_d;
    logic [MAX_DIM-1:0] width_q, width_d;
    logic [MAX_DIM-1:0] height_q, height_d;
    logic [31:0]        sh_stride_q, sh_stride_d;
    logic [31:0]        sh_colour_q, sh_colour_d;
    logic [MAX_DIM-1:0] sh_width_q, sh_width_d;
    logic [MAX_DIM-1:0] sh_height_q, sh_height_d;
    logic [MAX_DIM-1:0] x_q, x_d;
    logic [MAX_DIM-1:0] y_q, y_d;
    logic [31:0]        row_base_q, row_base_d;
    logic               abort_pend_q, abort_pend_d;
    logic               aborted_q, aborted_d;
    logic [31:0]        fills_q, fills_d;

    logic start_cmd;
    logic abort_cmd;
    logic fills_rd;
    logic accept;
    logic last_x;
    logic last_y;
    logic busy;

    // Abort takes priority over start when both bits arrive in one write.
    assign start_cmd = slave_write_en && (slave_address == A_CTRL) &&
                       slave_write_data[0] && !slave_write_data[1];
    assign abort_cmd = slave_write_en && (slave_address == A_CTRL) && slave_write_data[1];
    assign fills_rd  = slave_read_en && (slave_address == A_FILLS);
    assign accept    = (state_q == S_WRITE) && !master_wait_request;
    assign last_x    = (x_q == sh_width_q - MAX_DIM'(1));
    assign last_y    = (y_q == sh_height_q - MAX_DIM'(1));
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        stride_d     = stride_q;
        colour_d     = colour_q;
        width_d      = width_q;
        height_d     = height_q;
        sh_stride_d  = sh_stride_q;
        sh_colour_d  = sh_colour_q;
        sh_width_d   = sh_width_q;
        sh_height_d  = sh_height_q;
        x_d          = x_q;
        y_d          = y_q;
        row_base_d   = row_base_q;
        abort_pend_d = abort_pend_q;
        aborted_d    = aborted_q;
        fills_d      = fills_rd ? '0 : fills_q;

        if (slave_write_en) begin
            case (slave_address)
                A_BASE:   base_d   = slave_write_data;
                A_STRIDE: stride_d = slave_write_data;
                A_DIMS: begin
                    width_d  = slave_write_data[MAX_DIM-1:0];
                    height_d = slave_write_data[16 +: MAX_DIM];
                end
                A_COLOUR: colour_d = slave_write_data;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_cmd) begin
                    sh_stride_d = stride_q;
                    sh_colour_d = colour_q;
                    sh_width_d  = width_q;
                    sh_height_d = height_q;
                    x_d         = '0;
                    y_d         = '0;
                    row_base_d  = base_q;
                    aborted_d   = 1'b0;
                    if (width_q == '0 || height_q == '0) state_d = S_DONE;
                    else                                 state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // A presented beat cannot be withdrawn; abort waits for its accept.
                if (accept) begin
                    if (abort_pend_q || abort_cmd) begin
                        state_d      = S_IDLE;
                        aborted_d    = 1'b1;
                        abort_pend_d = 1'b0;
                    end else if (!last_x) begin
                        x_d = x_q + MAX_DIM'(1);
                    end else if (!last_y) begin
                        x_d        = '0;
                        y_d        = y_q + MAX_DIM'(1);
                        row_base_d = row_base_q + sh_stride_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (abort_cmd) begin
                    abort_pend_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                fills_d = fills_d + 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            stride_q     <= '0;
            colour_q     <= '0;
            width_q      <= '0;
            height_q     <= '0;
            sh_stride_q  <= '0;
            sh_colour_q  <= '0;
            sh_width_q   <= '0;
            sh_height_q  <= '0;
            x_q          <= '0;
            y_q          <= '0;
            row_base_q   <= '0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
            fills_q      <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            stride_q     <= stride_d;
            colour_q     <= colour_d;
            width_q      <= width_d;
            height_q     <= height_d;
            sh_stride_q  <= sh_stride_d;
            sh_colour_q  <= sh_colour_d;
            sh_width_q   <= sh_width_d;
            sh_height_q  <= sh_height_d;
            x_q          <= x_d;
            y_q          <= y_d;
            row_base_q   <= row_base_d;
            abort_pend_q <= abort_pend_d;
            aborted_q    <= aborted_d;
            fills_q      <= fills_d;
        end
    end

    // Address is derived from held registers, so it stays stable under waitrequest.
    assign master_write      = (state_q == S_WRITE);
    assign master_address    = row_base_q + (32'(x_q) << 2);
    assign master_write_data = sh_colour_q;

    always_comb begin
        slave_read_data = '0;
        case (slave_address)
            A_BASE:   slave_read_data = base_q;
            A_STRIDE: slave_read_data = stride_q;
            A_DIMS: begin
                slave_read_data[MAX_DIM-1:0]  = width_q;
                slave_read_data[16 +: MAX_DIM] = height_q;
            end
            A_COLOUR: slave_read_data = colour_q;
            A_CTRL:   slave_read_data = {30'd0, aborted_q, busy};
            A_FILLS:  slave_read_data = fills_q;
            default:  slave_read_data = '0;
        endcase
    end

`ifdef RECT_FILL_IRQ_EN
    logic irq_q, irq_d;

    // Set on DONE beats a same-cycle clear from reading the fill counter.
    always_comb begin
        irq_d = irq_q;
        if (fills_rd)             irq_d = 1'b0;
        if (state_q == S_DONE)    irq_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: beat scoreboard, stall generator, CSR checks.
`timescale 1ns/1ps
module tb_fb_rect_fill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  slave_address = '0;
    logic        slave_read_en = 1'b0;
    logic        slave_write_en = 1'b0;
    logic [31:0] slave_read_data;
    logic [31:0] slave_write_data = '0;
    logic [31:0] master_address;
    logic        master_write;
    logic [31:0] master_write_data;
    logic        master_wait_request;
`ifdef RECT_FILL_IRQ_EN
    logic        irq;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks  = 0;
    int    n_errors  = 0;
    int    acc_cnt   = 0;
    int    stall_obs = 0;
    int    acc_base  = 0;
    bit    mon_off   = 1'b0;
    int    stall_a   = -1;
    int    stall_b   = -1;
    int    stall_len = 0;

    fb_rect_fill dut (
`ifdef RECT_FILL_IRQ_EN
        .irq                 (irq),
`endif
        .clk                 (clk),
        .rst                 (rst),
        .slave_address       (slave_address),
        .slave_read_en       (slave_read_en),
        .slave_write_en      (slave_write_en),
        .slave_read_data     (slave_read_data),
        .slave_write_data    (slave_write_data),
        .master_address      (master_address),
        .master_write        (master_write),
        .master_write_data   (master_write_data),
        .master_wait_request (master_wait_request)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, between driver updates.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_addr, prev_data;
        beat_t       b;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (mon_off || rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_write", 32'(master_write), 32'd1);
                    chk("hold_addr", master_address, prev_addr);
                    chk("hold_data", master_write_data, prev_data);
                end
                prev_stall = master_write && master_wait_request;
                prev_addr  = master_address;
                prev_data  = master_write_data;
                if (master_write && master_wait_request) stall_obs++;
                if (master_write && !master_wait_request) begin
                    acc_cnt++;
                    n_checks++;
                    assert (exp_q.size() > 0) else begin
                        n_errors++;
                        $error("FAIL extra_beat: observed addr %h, expected no beat", master_address);
                    end
                    if (exp_q.size() > 0) begin
                        b = exp_q.pop_front();
                        chk("beat_addr", master_address, b.addr);
                        chk("beat_data", master_write_data, b.data);
                    end
                end
            end
        end
    end

    // Waitrequest generator: stalls selected beat indices for stall_len cycles.
    initial begin
        int stall_cnt, stall_seen;
        stall_cnt = 0;
        stall_seen = 0;
        master_wait_request = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (acc_cnt != stall_seen) begin
                stall_seen = acc_cnt;
                stall_cnt  = 0;
            end
            if (master_write && ((acc_cnt - acc_base) == stall_a || (acc_cnt - acc_base) == stall_b)
                && stall_cnt < stall_len) begin
                master_wait_request = 1'b1;
                stall_cnt++;
            end else begin
                master_wait_request = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        slave_address    = a;
        slave_write_data = d;
        slave_write_en   = 1'b1;
        tick();
        slave_write_en   = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        slave_address = a;
        slave_read_en = 1'b1;
        #1;
        d = slave_read_data;
        tick();
        slave_read_en = 1'b0;
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] v;
        csr_rd(a, v);
        chk(tag, v, exp);
    endtask

    task automatic program_fill(input logic [31:0] base, input logic [31:0] stride,
                                input logic [15:0] w, input logic [15:0] h, input logic [31:0] col);
        csr_wr(3'd0, base);
        csr_wr(3'd1, stride);
        csr_wr(3'd2, {h, w});
        csr_wr(3'd3, col);
    endtask

    task automatic push_fill(input logic [31:0] base, input logic [31:0] stride,
                             input int w, input int h, input logic [31:0] col, input int limit);
        int    n;
        beat_t b;
        n = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (n < limit) begin
                    b.addr = base + stride * 32'(y) + 32'(4 * x);
                    b.data = col;
                    exp_q.push_back(b);
                end
                n++;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] v;
        bit          idle;
        idle = 1'b0;
        for (int i = 0; i < 500 && !idle; i++) begin
            csr_rd(3'd4, v);
            idle = !v[0];
        end
        chk(tag, 32'(idle), 32'd1);
    endtask

    initial begin
        bit hit;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mwrite", 32'(master_write), 32'd0);
        chk("rst_maddr", master_address, 32'd0);
        chk("rst_mdata", master_write_data, 32'd0);
`ifdef RECT_FILL_IRQ_EN
        chk("rst_irq", 32'(irq), 32'd0);
`endif
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) rd_chk(3'(i), 32'd0, $sformatf("rst_csr%0d", i));

        // Simple 3x2 fill: six back-to-back beats starting the cycle after start
        program_fill(32'h1000, 32'd16, 16'd3, 16'd2, 32'hAABBCCDD);
        push_fill(32'h1000, 32'd16, 3, 2, 32'hAABBCCDD, 1000);
        acc_base = acc_cnt;
        csr_wr(3'd4, 32'h1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("simple_beat_cycle", 32'(master_write && !master_wait_request), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("simple_done_no_write", 32'(master_write), 32'd0);
        tick();
        wait_idle("simple_idle");
        chk("simple_sb_empty", 32'(exp_q.size()), 32'd0);
        rd_chk(3'd5, 32'd1, "simple_fills1");
        rd_chk(3'd5, 32'd0, "simple_fills_cleared");

        // Backpressure on beats 2 and 5, three cycles each
        stall_a = 1; stall_b = 4; stall_len = 3;
        push_fill(32'h1000, 32'd16, 3, 2, 32'hAABBCCDD, 1000);
        acc_base = acc_cnt;
        stall_obs = 0;
        csr_wr(3'd4, 32'h1);
        wait_idle("bp_idle");
        chk("bp_beats", 32'(acc_cnt - acc_base), 32'd6);
        chk("bp_stall_cycles", 32'(stall_obs), 32'd6);
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        rd_chk(3'd5, 32'd1, "bp_fills");
        stall_a = -1; stall_b = -1;

        // Zero width: straight to DONE, no bus traffic
        program_fill(32'h3000, 32'd64, 16'd0, 16'd5, 32'h1);
        acc_base = acc_cnt;
        csr_wr(3'd4, 32'h1);
        tick();
        rd_chk(3'd4, 32'd0, "zero_busy_clear");
        rd_chk(3'd5, 32'd1, "zero_fills");
        chk("zero_beats", 32'(acc_cnt - acc_base), 32'd0);

        // Abort during a stall on beat 10
        program_fill(32'h4000, 32'd400, 16'd100, 16'd1, 32'h12345678);
        push_fill(32'h4000, 32'd400, 100, 1, 32'h12345678, 10);
        stall_a = 9; stall_len = 4;
        acc_base = acc_cnt;
        csr_wr(3'd4, 32'h1);
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            hit = ((acc_cnt - acc_base) == 9) && master_wait_request;
        end
        chk("abort_reached_stall", 32'(hit), 32'd1);
        tick();
        csr_wr(3'd4, 32'h2);
        wait_idle("abort_idle");
        repeat (4) tick();
        chk("abort_beats", 32'(acc_cnt - acc_base), 32'd10);
        chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        rd_chk(3'd4, 32'h2, "abort_status");
        rd_chk(3'd5, 32'd0, "abort_fills");
        stall_a = -1;

        // Shadowing: colour change and restart while busy do not affect the running fill
        program_fill(32'h8000, 32'd64, 16'd8, 16'd2, 32'h11111111);
        push_fill(32'h8000, 32'd64, 8, 2, 32'h11111111, 1000);
        acc_base = acc_cnt;
        csr_wr(3'd4, 32'h1);
        rd_chk(3'd4, 32'h1, "shadow_busy_aborted_cleared");
        csr_wr(3'd3, 32'h0);
        csr_wr(3'd4, 32'h1);
        wait_idle("shadow_idle");
        chk("shadow_beats", 32'(acc_cnt - acc_base), 32'd16);
        chk("shadow_sb_empty", 32'(exp_q.size()), 32'd0);
        rd_chk(3'd5, 32'd1, "shadow_one_fill");
        csr_wr(3'd2, {16'd1, 16'd2});
        push_fill(32'h8000, 32'd64, 2, 1, 32'h0, 1000);
        csr_wr(3'd4, 32'h1);
        wait_idle("shadow2_idle");
        chk("shadow2_sb_empty", 32'(exp_q.size()), 32'd0);
        rd_chk(3'd5, 32'd1, "shadow2_fills");

        // Negative stride with 32-bit address wrap
        program_fill(32'hFFFFFFFC, 32'hFFFFFFF8, 16'd2, 16'd2, 32'hCAFEF00D);
        push_fill(32'hFFFFFFFC, 32'hFFFFFFF8, 2, 2, 32'hCAFEF00D, 1000);
        csr_wr(3'd4, 32'h1);
        wait_idle("wrap_idle");
        chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
        rd_chk(3'd5, 32'd1, "wrap_fills");

        // Reset in the middle of a fill
        program_fill(32'h100, 32'd0, 16'd50, 16'd1, 32'h5);
        mon_off = 1'b1;
        csr_wr(3'd4, 32'h1);
        repeat (5) tick();
        chk("midrst_writing", 32'(master_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_write_drop", 32'(master_write), 32'd0);
        chk("midrst_addr", master_address, 32'd0);
        tick();
        rst = 1'b0;
        mon_off = 1'b0;
        tick();
        rd_chk(3'd0, 32'd0, "midrst_base_cleared");
        rd_chk(3'd4, 32'd0, "midrst_idle");

`ifdef RECT_FILL_IRQ_EN
        // IRQ: counter read during DONE must not lose the set
        program_fill(32'h200, 32'd4, 16'd1, 16'd1, 32'h77);
        push_fill(32'h200, 32'd4, 1, 1, 32'h77, 1000);
        csr_wr(3'd4, 32'h1);
        tick();
        chk("irq_before_done", 32'(irq), 32'd0);
        rd_chk(3'd5, 32'd0, "irq_read_in_done");
        chk("irq_set_wins", 32'(irq), 32'd1);
        rd_chk(3'd5, 32'd1, "irq_fills");
        chk("irq_cleared", 32'(irq), 32'd0);
`endif

        repeat (5) tick();
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fb_rect_fill.md
Name: fb_rect_fill

Overview:
- Avalon-MM write-master engine that fills a rectangle of 32-bit pixels in the SDRAM framebuffer with a constant colour.
- Write-side counterpart to the scanout controller's SDRAM read master; shares the same SDRAM arbiter port type.
- CPU programs it through an Avalon slave CSR block, starts it, then polls status or a completion counter before flipping buffers.

Parameters:
- MAX_DIM, 16, width of the width/height fields in bits; the maximum rectangle edge is 2^MAX_DIM-1 pixels.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- slave_address  in  3  CSR word index
- slave_read_en  in  1  CSR read strobe
- slave_write_en  in  1  CSR write strobe
- slave_read_data  out  32  CSR read data, combinational from slave_address
- slave_write_data  in  32  CSR write data
- master_address  out  32  SDRAM byte address
- master_write  out  1  write request
- master_write_data  out  32  pixel data
- master_wait_request  in  1  Avalon waitrequest from SDRAM
- irq  out  1  completion interrupt; only present with RECT_FILL_IRQ_EN

Behaviour:
- CSR map (index: access, meaning):
  - 0: RW, base byte address.
  - 1: RW, stride in bytes, 32-bit.
  - 2: RW, [MAX_DIM-1:0] width in pixels, [16+MAX_DIM-1:16] height.
  - 3: RW, colour.
  - 4 write: bit0 start, bit1 abort.
  - 4 read: bit0 busy, bit1 aborted-sticky.
  - 5: RO, fills_done count, cleared on read.
  - 6, 7: read 0, writes ignored.
- CSRs 0-3 are writable at any time. On the start cycle they are copied into shadow registers; the running fill uses only the shadows.
- Reset: every CSR, shadow and counter is 0; master_write=0; master_address=0; master_write_data=0; irq=0; state IDLE.
- States:
  - IDLE: start=1 latches the shadows.
    - width=0 or height=0: go to DONE with no bus writes.
    - Otherwise: go to WRITE; x=0, y=0, row_base=base.
  - WRITE: master_write=1, master_address=row_base+4*x, master_write_data=colour.
    - A beat is accepted when master_write=1 and master_wait_request=0.
    - While master_wait_request=1, address, data and write stay stable.
    - On accept with x<width-1: x increments and the next address is presented in the following cycle (no bubble).
    - On accept with x=width-1 and y<height-1: x=0, y increments, row_base+=stride, also with no bubble.
    - On accept of the final pixel: go to DONE.
  - DONE: one cycle. busy deasserts, fills_done increments, then go to IDLE.
- Latency: an unstalled W×H fill takes 1 cycle (start to first write) + W×H write cycles + 1 DONE cycle. busy reads 0 on the cycle after DONE.
- start while busy is ignored.
- Abort while in WRITE:
  - The beat currently presented still completes, because Avalon forbids withdrawing a request under waitrequest.
  - After that accept the block goes to IDLE and sets aborted.
  - fills_done does not increment.
  - Abort in IDLE/DONE is ignored.
  - start clears aborted.
- start and abort in the same write: abort wins, so no fill begins.
- fills_done read in the same cycle DONE increments it: the counter becomes 1, not 0.
- Address arithmetic is 32-bit modulo with no bounds check. A stride smaller than 4×width, including a negative two's-complement stride, is legal and not corrected.
- rst mid-fill: master_write drops immediately and state returns to IDLE; the partial frame is left as is.

Optional Feature:
- RECT_FILL_IRQ_EN
- Defined:
  - irq port exists and is set on the DONE cycle.
  - irq is cleared by a read of CSR 5, or by reset.
  - If a clear and a set happen in the same cycle, set wins.
  - Abort does not set irq.
- Undefined: no irq port and no associated logic; the CSR map is unchanged.

Test Plan:
- Simple fill: base=0x1000, stride=16, W=3, H=2, colour=0xAABBCCDD, start.
  - Required: writes to 0x1000, 0x1004, 0x1008, 0x1010, 0x1014, 0x1018, in 6 consecutive cycles.
  - Required: busy=0 afterwards; CSR5 reads 1, then 0.
- Backpressure: same fill with wait_request high for 3 cycles on the 2nd and 5th beats.
  - Required: address and data are held during each stall; exactly 6 accepted beats; no duplicates.
- Zero size: W=0, H=5, start.
  - Required: no master_write; busy clears within 2 cycles; CSR5=1.
- Abort: W=100, H=1, stall on beat 10, abort issued during the stall.
  - Required: beat 10 is accepted; no beat 11; CSR4 reads 0x2; CSR5=0.
- Shadowing and ignored start: during a fill, write colour=0x0 and start again.
  - Required: the running fill keeps the old colour; only 1 fill is counted.
  - Required: a later start uses 0x0.
- IRQ (macro defined): irq rises on DONE; read CSR5 in the DONE cycle.
  - Required: irq stays 1 and CSR5 becomes 1. A second read clears both.
